ex_ctrl: RTL
============

# ex_ctrl

Sequencing controller for the execute stage. Decides each cycle whether the instruction in id2ex issues, stalls for a load-use hazard, or is held because the memory stage is busy. While held, it directs the EX operand buffers to capture and replay forwarded rs1/rs2 values, so that draining later stages do not corrupt the operands. It sits between the id2ex register, the EX datapath buffer controls and the ex2mem handshake.

## Interface
Parameters: none; widths come from `defines.v` (`REG_INDEX_BUS` = 5 bits).

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- ex_ctrl_inst_valid_i  in  1  id2ex holds a valid instruction
- ex_ctrl_flush_i  in  1  branch/trap flush of the EX stage
- ex_ctrl_mem_ready_i  in  1  MEM stage accepts ex2mem this cycle
- ex_ctrl_id2ex_rs1_en_i / _rs2_en_i  in  1  source register used
- ex_ctrl_id2ex_rs1_index_i / _rs2_index_i  in  REG_INDEX_BUS  source indices
- ex_ctrl_ex2mem_valid_i  in  1  ex2mem holds a valid instruction
- ex_ctrl_ex2mem_mem_read_i  in  1  ex2mem instruction is a load
- ex_ctrl_ex2mem_rd_en_i  in  1  ex2mem writes rd
- ex_ctrl_ex2mem_rd_index_i  in  REG_INDEX_BUS  ex2mem rd index
- ex_ctrl_ex_valid_o  out  1  EX result valid toward ex2mem
- ex_ctrl_ex_ready_o  out  1  id2ex may load the next instruction
- ex_ctrl_rs1_buffered_o / _rs2_buffered_o  out  1  capture pulse for the operand buffer
- ex_ctrl_rs1_src_buffer_o / _rs2_src_buffer_o  out  1  EX operand taken from the buffer
- ex_ctrl_lu_stall_o  out  1  load-use stall active
- ex_ctrl_hold_cnt_o  out  32  held-cycle counter (see Configuration)
- ex_ctrl_lu_cnt_o  out  32  load-use stall cycle counter (see Configuration)

## Operation
- State register has two states: RUN and HOLD. Sticky flags buf1 and buf2 record which operands were captured.
- Hazard: `lu` = ex2mem_valid & mem_read & rd_en & (rd_index != 0) & ((rs1_en & rs1_index == rd_index) | (rs2_en & rs2_index == rd_index)).
- RUN with !inst_valid (idle):
  - ex_valid = 0, ex_ready = 1.
- RUN with inst_valid & lu:
  - ex_valid = 0 (bubble into ex2mem), ex_ready = 0, lu_stall = 1.
  - Remains in RUN; the stall clears when the load advances out of ex2mem.
- RUN with inst_valid & !lu (execute):
  - ex_valid = 1, ex_ready = mem_ready.
  - If !mem_ready: rs1_buffered = rs1_en and rs2_buffered = rs2_en; buf1/buf2 load those values; next state is HOLD.
- HOLD:
  - ex_valid = 1, ex_ready = mem_ready.
  - src_buffer outputs = buf1/buf2; rs*_buffered = 0; lu is ignored.
  - On mem_ready: next state is RUN and buf1/buf2 clear.
- Flush, in any state:
  - ex_valid = 0, ex_ready = 1, rs*_buffered = 0.
  - Next state is RUN and buf flags clear.
  - Flush wins over mem_ready, lu and hold entry.

## Timing
- rst low: state RUN, buf flags 0, counters 0. All outputs are forced to 0 while rst is low, including ex_ready.
- Everything leaves reset cleanly from the first rising edge after rst is released.
- ex_valid, ex_ready, rs*_buffered and lu_stall are combinational from the inputs and state.
- rs*_src_buffer is registered and asserted from the cycle after the capture pulse.
- Capture timing: the buffered pulse and the datapath register load share the same edge. The HOLD cycle then reads the buffer at zero added latency.
- Minimum HOLD duration is 1 cycle; there is no upper bound.
- mem_ready high in the execute cycle: no HOLD and no capture; the instruction retires in 1 cycle.
- A load-use stall lasts until ex2mem advances: exactly 1 cycle if mem_ready is high during the stall cycle.

## Configuration
- `EX_CTRL_PERF_EN` defined:
  - hold_cnt increments every cycle the state is HOLD and no flush is present.
  - lu_cnt increments every cycle lu_stall = 1.
  - Both are 32-bit, wrap from 0xFFFF_FFFF to 0, and reset to 0.
- `EX_CTRL_PERF_EN` undefined: both ports remain and are driven constant 0; no counter flops are built.

## Test plan
- Reset: hold rst low with inputs toggling -> all outputs 0. Release rst, inst_valid = 1, mem_ready = 1, no hazard -> ex_valid = 1, ex_ready = 1 on the first cycle.
- Hold: execute with rs1_en = 1, rs2_en = 0, mem_ready = 0 for 3 cycles, then 1.
  - rs1_buffered pulses in cycle 0.
  - rs1_src_buffer = 1 in cycles 1–3; rs2_src_buffer = 0.
  - ex_ready = 1 only in cycle 3; RUN in cycle 4.
- Load-use: ex2mem load to x5, id2ex rs2 = x5, mem_ready = 1 -> one cycle with ex_valid = 0, ex_ready = 0, lu_stall = 1, then normal issue.
- x0 exemption: ex2mem load to x0, id2ex rs1 = x0 -> no stall.
- Flush mid-HOLD: flush together with mem_ready = 1 in the 2nd HOLD cycle -> ex_valid = 0, next cycle RUN with src_buffer = 0.
- Counters (`EX_CTRL_PERF_EN` defined): 4 HOLD cycles plus 2 lu cycles -> hold_cnt = 4, lu_cnt = 2. Preload via force to 0xFFFF_FFFF, one HOLD cycle -> 0.

Source files
------------

// File: rtl/ex_ctrl.sv
// Execute-stage sequencing controller: issue / load-use stall / hold with operand replay.
// Optional performance counters are built when EX_CTRL_PERF_EN is defined.
`ifndef REG_INDEX_BUS
`define REG_INDEX_BUS 5
`endif

module ex_ctrl (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      ex_ctrl_inst_valid_i,
   input  logic                      ex_ctrl_flush_i,
   input  logic                      ex_ctrl_mem_ready_i,
   input  logic                      ex_ctrl_id2ex_rs1_en_i,
   input  logic                      ex_ctrl_id2ex_rs2_en_i,
   input  logic [`REG_INDEX_BUS-1:0] ex_ctrl_id2ex_rs1_index_i,
   input  logic [`REG_INDEX_BUS-1:0] ex_ctrl_id2ex_rs2_index_i,
   input  logic                      ex_ctrl_ex2mem_valid_i,
   input  logic                      ex_ctrl_ex2mem_mem_read_i,
   input  logic                      ex_ctrl_ex2mem_rd_en_i,
   input  logic [`REG_INDEX_BUS-1:0] ex_ctrl_ex2mem_rd_index_i,
   output logic                      ex_ctrl_ex_valid_o,
   output logic                      ex_ctrl_ex_ready_o,
   output logic                      ex_ctrl_rs1_buffered_o,
   output logic                      ex_ctrl_rs2_buffered_o,
   output logic                      ex_ctrl_rs1_src_buffer_o,
   output logic                      ex_ctrl_rs2_src_buffer_o,
   output logic                      ex_ctrl_lu_stall_o,
   output logic [31:0]               ex_ctrl_hold_cnt_o,
   output logic [31:0]               ex_ctrl_lu_cnt_o
);

   typedef enum logic {
      RUN  = 1'b0,
      HOLD = 1'b1
   } state_t;

   state_t state_p1, state_d;
   logic   buf1_p1, buf2_p1, buf1_d, buf2_d;
   logic   lu;
   logic   ex_valid, ex_ready, rs1_buf, rs2_buf, lu_stall;
   logic   rs1_hit, rs2_hit;

   // Load in ex2mem whose rd feeds an id2ex source; x0 never creates a dependency.
   assign rs1_hit = ex_ctrl_id2ex_rs1_en_i &&
                    (ex_ctrl_id2ex_rs1_index_i == ex_ctrl_ex2mem_rd_index_i);
   assign rs2_hit = ex_ctrl_id2ex_rs2_en_i &&
                    (ex_ctrl_id2ex_rs2_index_i == ex_ctrl_ex2mem_rd_index_i);
   assign lu = ex_ctrl_ex2mem_valid_i && ex_ctrl_ex2mem_mem_read_i &&
               ex_ctrl_ex2mem_rd_en_i && (ex_ctrl_ex2mem_rd_index_i != '0) &&
               (rs1_hit || rs2_hit);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_p1 <= RUN;
         buf1_p1  <= 1'b0;
         buf2_p1  <= 1'b0;
      end else begin
         state_p1 <= state_d;
         buf1_p1  <= buf1_d;
         buf2_p1  <= buf2_d;
      end
   end

   always_comb begin
      state_d  = state_p1;
      buf1_d   = buf1_p1;
      buf2_d   = buf2_p1;
      ex_valid = 1'b0;
      ex_ready = 1'b0;
      rs1_buf  = 1'b0;
      rs2_buf  = 1'b0;
      lu_stall = 1'b0;
      if (ex_ctrl_flush_i) begin
         ex_ready = 1'b1;
         state_d  = RUN;
         buf1_d   = 1'b0;
         buf2_d   = 1'b0;
      end else begin
         case (state_p1)
            RUN: begin
               if (!ex_ctrl_inst_valid_i) begin
                  ex_ready = 1'b1;
               end else if (lu) begin
                  lu_stall = 1'b1;
               end else begin
                  ex_valid = 1'b1;
                  ex_ready = ex_ctrl_mem_ready_i;
                  // Capture on the same edge the datapath buffer loads, then replay in HOLD.
                  if (!ex_ctrl_mem_ready_i) begin
                     rs1_buf = ex_ctrl_id2ex_rs1_en_i;
                     rs2_buf = ex_ctrl_id2ex_rs2_en_i;
                     buf1_d  = ex_ctrl_id2ex_rs1_en_i;
                     buf2_d  = ex_ctrl_id2ex_rs2_en_i;
                     state_d = HOLD;
                  end
               end
            end
            HOLD: begin
               ex_valid = 1'b1;
               ex_ready = ex_ctrl_mem_ready_i;
               if (ex_ctrl_mem_ready_i) begin
                  state_d = RUN;
                  buf1_d  = 1'b0;
                  buf2_d  = 1'b0;
               end
            end
            default: begin
               state_d = RUN;
               buf1_d  = 1'b0;
               buf2_d  = 1'b0;
            end
         endcase
      end
   end

   // Combinational controls are held low for the whole reset interval.
   assign ex_ctrl_ex_valid_o       = rst & ex_valid;
   assign ex_ctrl_ex_ready_o       = rst & ex_ready;
   assign ex_ctrl_rs1_buffered_o   = rst & rs1_buf;
   assign ex_ctrl_rs2_buffered_o   = rst & rs2_buf;
   assign ex_ctrl_lu_stall_o       = rst & lu_stall;
   assign ex_ctrl_rs1_src_buffer_o = buf1_p1;
   assign ex_ctrl_rs2_src_buffer_o = buf2_p1;

`ifdef EX_CTRL_PERF_EN
   logic [31:0] hold_cnt_p1, lu_cnt_p1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hold_cnt_p1 <= '0;
         lu_cnt_p1   <= '0;
      end else begin
         if ((state_p1 == HOLD) && !ex_ctrl_flush_i)
            hold_cnt_p1 <= hold_cnt_p1 + 32'd1;
         if (lu_stall)
            lu_cnt_p1 <= lu_cnt_p1 + 32'd1;
      end
   end

   assign ex_ctrl_hold_cnt_o = hold_cnt_p1;
   assign ex_ctrl_lu_cnt_o   = lu_cnt_p1;
`else
   assign ex_ctrl_hold_cnt_o = '0;
   assign ex_ctrl_lu_cnt_o   = '0;
`endif

endmodule
